// File: rtl/ps2_ace_keyboard.sv
// PS/2 set-2 keyboard front end for the Jupiter Ace: receives frames, tracks an
// 8x5 key matrix and answers row selects (filas) with active-low columns.
//
// state   | meaning
// S_IDLE  | waiting for a start bit
// S_RECV  | shifting in data, parity and stop bits
// S_CHECK | one cycle to validate the frame and hand the byte to the decoder
module ps2_ace_keyboard #(
    parameter int TIMEOUT_CYCLES = 6500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2clk,
    input  logic       ps2data,
    input  logic [7:0] filas,
    output logic [4:0] columnas,
    output logic [7:0] scancode,
    output logic       scancode_valid
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK} state_t;

    state_t          state_q, state_d;
    logic [1:0]      clk_sync_q, dat_sync_q;
    logic            clk_prev_q;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [9:0]      sr_q, sr_d;
    logic [TW-1:0]   tmr_q;
    logic            ext_q, brk_q;
    logic [7:0][4:0] matrix_q;
    logic [7:0]      scancode_q;
    logic            valid_q;

    logic            fall, ps2_bit, timed_out;
    logic            frame_ok, frame_bad;
    logic [7:0]      code;
    logic            key_hit;
    logic [2:0]      key_row, key_col;

    assign fall      = clk_prev_q & ~clk_sync_q[1];
    assign ps2_bit   = dat_sync_q[1];
    assign timed_out = (tmr_q == '0);
    assign code      = sr_q[7:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2clk};
            dat_sync_q <= {dat_sync_q[0], ps2data};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    // Inactivity timer: reloaded on every PS/2 falling edge, counts down to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr_q <= TIMEOUT_CYCLES[TW-1:0];
        end else if (fall) begin
            tmr_q <= TIMEOUT_CYCLES[TW-1:0];
        end else if (!timed_out) begin
            tmr_q <= tmr_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            sr_q     <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            sr_q     <= sr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        sr_d      = sr_q;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall && !ps2_bit) begin
                    state_d  = S_RECV;
                    bitcnt_d = '0;
                end
            end
            S_RECV: begin
                if (fall) begin
                    // Shift in at the top so that after 10 bits: [7:0]=data, [8]=parity, [9]=stop.
                    sr_d = {ps2_bit, sr_q[9:1]};
                    if (bitcnt_q == 4'd9) begin
                        state_d = S_CHECK;
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end else if (timed_out) begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                state_d   = S_IDLE;
                frame_ok  = (^sr_q[8:0]) & sr_q[9];
                frame_bad = ~frame_ok;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        key_hit = 1'b0;
        key_row = 3'd0;
        key_col = 3'd0;
        if (ext_q) begin
            case (code)
                8'h14: {key_hit, key_row, key_col} = {1'b1, 3'd0, 3'd1};
                8'h5A: {key_hit, key_row, key_col} = {1'b1, 3'd6, 3'd0};
                default: ;
            endcase
        end else begin
            case (code)
                8'h12, 8'h59: {key_hit, key_row, key_col} = {1'b1, 3'd0, 3'd0};
                8'h14: {key_hit, key_row, key_col} = {1'b1, 3'd0, 3'd1};
                8'h1A: {key_hit, key_row, key_col} = {1'b1, 3'd0, 3'd2};
                8'h22: {key_hit, key_row, key_col} = {1'b1, 3'd0, 3'd3};
                8'h21: {key_hit, key_row, key_col} = {1'b1, 3'd0, 3'd4};
                8'h1C: {key_hit, key_row, key_col} = {1'b1, 3'd1, 3'd0};
                8'h1B: {key_hit, key_row, key_col} = {1'b1, 3'd1, 3'd1};
                8'h23: {key_hit, key_row, key_col} = {1'b1, 3'd1, 3'd2};
                8'h2B: {key_hit, key_row, key_col} = {1'b1, 3'd1, 3'd3};
                8'h34: {key_hit, key_row, key_col} = {1'b1, 3'd1, 3'd4};
                8'h15: {key_hit, key_row, key_col} = {1'b1, 3'd2, 3'd0};
                8'h1D: {key_hit, key_row, key_col} = {1'b1, 3'd2, 3'd1};
                8'h24: {key_hit, key_row, key_col} = {1'b1, 3'd2, 3'd2};
                8'h2D: {key_hit, key_row, key_col} = {1'b1, 3'd2, 3'd3};
                8'h2C: {key_hit, key_row, key_col} = {1'b1, 3'd2, 3'd4};
                8'h16: {key_hit, key_row, key_col} = {1'b1, 3'd3, 3'd0};
                8'h1E: {key_hit, key_row, key_col} = {1'b1, 3'd3, 3'd1};
                8'h26: {key_hit, key_row, key_col} = {1'b1, 3'd3, 3'd2};
                8'h25: {key_hit, key_row, key_col} = {1'b1, 3'd3, 3'd3};
                8'h2E: {key_hit, key_row, key_col} = {1'b1, 3'd3, 3'd4};
                8'h45: {key_hit, key_row, key_col} = {1'b1, 3'd4, 3'd0};
                8'h46: {key_hit, key_row, key_col} = {1'b1, 3'd4, 3'd1};
                8'h3E: {key_hit, key_row, key_col} = {1'b1, 3'd4, 3'd2};
                8'h3D: {key_hit, key_row, key_col} = {1'b1, 3'd4, 3'd3};
                8'h36: {key_hit, key_row, key_col} = {1'b1, 3'd4, 3'd4};
                8'h4D: {key_hit, key_row, key_col} = {1'b1, 3'd5, 3'd0};
                8'h44: {key_hit, key_row, key_col} = {1'b1, 3'd5, 3'd1};
                8'h43: {key_hit, key_row, key_col} = {1'b1, 3'd5, 3'd2};
                8'h3C: {key_hit, key_row, key_col} = {1'b1, 3'd5, 3'd3};
                8'h35: {key_hit, key_row, key_col} = {1'b1, 3'd5, 3'd4};
                8'h5A: {key_hit, key_row, key_col} = {1'b1, 3'd6, 3'd0};
                8'h4B: {key_hit, key_row, key_col} = {1'b1, 3'd6, 3'd1};
                8'h42: {key_hit, key_row, key_col} = {1'b1, 3'd6, 3'd2};
                8'h3B: {key_hit, key_row, key_col} = {1'b1, 3'd6, 3'd3};
                8'h33: {key_hit, key_row, key_col} = {1'b1, 3'd6, 3'd4};
                8'h29: {key_hit, key_row, key_col} = {1'b1, 3'd7, 3'd0};
                8'h3A: {key_hit, key_row, key_col} = {1'b1, 3'd7, 3'd1};
                8'h31: {key_hit, key_row, key_col} = {1'b1, 3'd7, 3'd2};
                8'h32: {key_hit, key_row, key_col} = {1'b1, 3'd7, 3'd3};
                8'h2A: {key_hit, key_row, key_col} = {1'b1, 3'd7, 3'd4};
                default: ;
            endcase
        end
    end

    // Decoder: prefixes only set flags; any other accepted byte consumes them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            matrix_q   <= '1;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            scancode_q <= 8'h00;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (frame_ok) begin
                scancode_q <= code;
                valid_q    <= 1'b1;
                if (code == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (code == 8'hF0) begin
                    brk_q <= 1'b1;
                end else begin
                    if (key_hit) begin
                        matrix_q[key_row][key_col] <= brk_q;
                    end
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end
            end else if (frame_bad) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

    always_comb begin
        columnas = 5'b11111;
        for (int r = 0; r < 8; r++) begin
            if (!filas[r]) begin
                columnas = columnas & matrix_q[r];
            end
        end
    end

    assign scancode       = scancode_q;
    assign scancode_valid = valid_q;

endmodule

// File: tb/tb_ps2_ace_keyboard.sv
// Bench for ps2_ace_keyboard: PS/2 frames driven bit by bit, results checked
// against a key-matrix model built from the set-2 key table.
module tb_ps2_ace_keyboard;

    localparam int TIMEOUT = 6500;
    localparam int HALF    = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2clk;
    logic       ps2data;
    logic [7:0] filas;
    logic [4:0] columnas;
    logic [7:0] scancode;
    logic       scancode_valid;

    int total  = 0;
    int passed = 0;
    int pulses = 0;

    // Reference model state
    logic [4:0] m_mat [8];
    bit         m_ext, m_brk;
    logic [7:0] m_sc;
    int         m_pulses = 0;

    // Key table, index = row*5 + col (SHIFT also has the alias 59)
    logic [7:0] ktab [40] = '{
        8'h12, 8'h14, 8'h1A, 8'h22, 8'h21,
        8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
        8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
        8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
        8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,
        8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
        8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,
        8'h29, 8'h3A, 8'h31, 8'h32, 8'h2A
    };

    ps2_ace_keyboard #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk            (clk),
        .reset          (reset),
        .ps2clk         (ps2clk),
        .ps2data        (ps2data),
        .filas          (filas),
        .columnas       (columnas),
        .scancode       (scancode),
        .scancode_valid (scancode_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (scancode_valid === 1'b1) pulses++;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void model_reset();
        for (int r = 0; r < 8; r++) m_mat[r] = 5'b11111;
        m_ext = 0;
        m_brk = 0;
        m_sc  = 8'h00;
    endfunction

    function automatic void model_lookup(input logic [7:0] c, input bit e,
                                         output bit hit, output int r, output int k);
        hit = 0; r = 0; k = 0;
        if (e) begin
            if (c == 8'h14) begin hit = 1; r = 0; k = 1; end
            if (c == 8'h5A) begin hit = 1; r = 6; k = 0; end
        end else if (c == 8'h59) begin
            hit = 1; r = 0; k = 0;
        end else begin
            for (int i = 0; i < 40; i++)
                if (ktab[i] == c) begin hit = 1; r = i / 5; k = i % 5; end
        end
    endfunction

    function automatic void model_frame(input logic [7:0] b, input bit bad);
        bit hit;
        int r, k;
        if (bad) begin
            m_ext = 0;
            m_brk = 0;
            return;
        end
        m_sc = b;
        m_pulses++;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            model_lookup(b, m_ext, hit, r, k);
            if (hit) m_mat[r][k] = m_brk;
            m_ext = 0;
            m_brk = 0;
        end
    endfunction

    function automatic logic [4:0] exp_cols(input logic [7:0] f);
        logic [4:0] res = 5'b11111;
        for (int r = 0; r < 8; r++) if (!f[r]) res = res & m_mat[r];
        return res;
    endfunction

    task automatic send_bits(input logic [7:0] b, input bit bad, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2data = fr[i];
            repeat (HALF) @(posedge clk);
            ps2clk = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2clk = 1'b1;
        end
        ps2data = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    task automatic send_key(input logic [7:0] b, input bit bad);
        send_bits(b, bad, 11);
        model_frame(b, bad);
    endtask

    task automatic set_filas(input logic [7:0] f);
        @(negedge clk);
        filas = f;
        #1;
    endtask

    task automatic test_reset();
        set_filas(8'hFE);
        total++; if (columnas !== 5'b11111) $display("FAIL reset_cols got %b want %b", columnas, 5'b11111); else passed++;
        total++; if (scancode !== 8'h00) $display("FAIL reset_scancode got %h want 00", scancode); else passed++;
        total++; if (scancode_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", scancode_valid); else passed++;
        send_key(8'h1A, 0);
        set_filas(8'hFE);
        total++; if (columnas !== exp_cols(8'hFE)) $display("FAIL held_z got %b want %b", columnas, exp_cols(8'hFE)); else passed++;
        reset = 1'b0;
        model_reset();
        #3;
        total++; if (columnas !== 5'b11111) $display("FAIL reset_held_cols got %b want %b", columnas, 5'b11111); else passed++;
        total++; if (scancode !== 8'h00) $display("FAIL reset_held_scancode got %h want 00", scancode); else passed++;
        repeat (3) @(posedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_press_release();
        int p0;
        p0 = pulses;
        send_key(8'h1C, 0);
        set_filas(8'hFD);
        total++; if (columnas !== exp_cols(8'hFD)) $display("FAIL press_a got %b want %b", columnas, exp_cols(8'hFD)); else passed++;
        total++; if (scancode !== 8'h1C) $display("FAIL press_a_sc got %h want 1c", scancode); else passed++;
        total++; if (pulses - p0 !== 1) $display("FAIL press_a_pulses got %0d want 1", pulses - p0); else passed++;
        send_key(8'hF0, 0);
        send_key(8'h1C, 0);
        set_filas(8'hFD);
        total++; if (columnas !== exp_cols(8'hFD)) $display("FAIL release_a got %b want %b", columnas, exp_cols(8'hFD)); else passed++;
        total++; if (pulses - p0 !== 3) $display("FAIL release_a_pulses got %0d want 3", pulses - p0); else passed++;
    endtask

    task automatic test_multi_row();
        logic [7:0] fl [4] = '{8'hFE, 8'h7F, 8'h7E, 8'hFF};
        send_key(8'h12, 0);
        send_key(8'h29, 0);
        for (int i = 0; i < 4; i++) begin
            set_filas(fl[i]);
            total++; if (columnas !== exp_cols(fl[i])) $display("FAIL multi_row filas=%h got %b want %b", fl[i], columnas, exp_cols(fl[i])); else passed++;
        end
        send_key(8'hF0, 0);
        send_key(8'h12, 0);
    endtask

    task automatic test_ext();
        send_key(8'hE0, 0);
        send_key(8'h14, 0);
        set_filas(8'hFE);
        total++; if (columnas !== exp_cols(8'hFE)) $display("FAIL ext_sym got %b want %b", columnas, exp_cols(8'hFE)); else passed++;
        send_key(8'hE0, 0);
        send_key(8'hF0, 0);
        send_key(8'h14, 0);
        set_filas(8'hFE);
        total++; if (columnas !== exp_cols(8'hFE)) $display("FAIL ext_sym_rel got %b want %b", columnas, exp_cols(8'hFE)); else passed++;
        send_key(8'hE0, 0);
        send_key(8'h75, 0);
        send_key(8'h1A, 0);
        set_filas(8'hFE);
        total++; if (columnas !== exp_cols(8'hFE)) $display("FAIL ext_unmapped_then_z got %b want %b", columnas, exp_cols(8'hFE)); else passed++;
        send_key(8'hF0, 0);
        send_key(8'h1A, 0);
    endtask

    task automatic test_errors();
        int p0;
        p0 = pulses;
        send_key(8'h1C, 1);
        set_filas(8'hFD);
        total++; if (pulses - p0 !== 0) $display("FAIL parity_pulses got %0d want 0", pulses - p0); else passed++;
        total++; if (columnas !== exp_cols(8'hFD)) $display("FAIL parity_cols got %b want %b", columnas, exp_cols(8'hFD)); else passed++;
        send_bits(8'h1C, 0, 6);
        repeat (TIMEOUT + 10) @(posedge clk);
        p0 = pulses;
        send_key(8'h1C, 0);
        set_filas(8'hFD);
        total++; if (pulses - p0 !== 1) $display("FAIL timeout_pulses got %0d want 1", pulses - p0); else passed++;
        total++; if (scancode !== 8'h1C) $display("FAIL timeout_sc got %h want 1c", scancode); else passed++;
        total++; if (columnas !== exp_cols(8'hFD)) $display("FAIL timeout_cols got %b want %b", columnas, exp_cols(8'hFD)); else passed++;
        send_key(8'hF0, 0);
        send_key(8'h1C, 0);
    endtask

    task automatic test_reset_mid_frame();
        send_bits(8'h4D, 0, 4);
        reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        send_key(8'h22, 0);
        set_filas(8'hFE);
        total++; if (columnas !== exp_cols(8'hFE)) $display("FAIL midreset_x got %b want %b", columnas, exp_cols(8'hFE)); else passed++;
        total++; if (scancode !== 8'h22) $display("FAIL midreset_sc got %h want 22", scancode); else passed++;
    endtask

    task automatic test_random();
        logic [7:0] c, f;
        int idx;
        bit bad;
        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 49);
            if (idx < 40) c = ktab[idx];
            else case (idx)
                40: c = 8'h59;
                41: c = 8'hAA;
                42: c = 8'hFA;
                43, 44, 45: c = 8'hF0;
                46, 47: c = 8'hE0;
                48: c = 8'h5A;
                default: c = 8'h75;
            endcase
            bad = ($urandom_range(0, 9) == 0);
            send_key(c, bad);
            f = 8'($urandom);
            set_filas(f);
            total++; if (columnas !== exp_cols(f)) $display("FAIL rand_cols n=%0d code=%h filas=%h got %b want %b", n, c, f, columnas, exp_cols(f)); else passed++;
            total++; if (scancode !== m_sc) $display("FAIL rand_sc n=%0d got %h want %h", n, scancode, m_sc); else passed++;
            total++; if (pulses !== m_pulses) $display("FAIL rand_pulses n=%0d got %0d want %0d", n, pulses, m_pulses); else passed++;
        end
    endtask

    initial begin
        reset   = 1'b0;
        ps2clk  = 1'b1;
        ps2data = 1'b1;
        filas   = 8'hFF;
        model_reset();
        repeat (5) @(posedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        test_reset();
        m_pulses = pulses;
        test_press_release();
        test_multi_row();
        test_ext();
        test_errors();
        test_reset_mid_frame();
        m_pulses = pulses;
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ps2_ace_keyboard.md
Name: ps2_ace_keyboard

Overview:
PS/2 keyboard front end for the Jupiter Ace core. It receives scan-code set 2 frames from a PS/2 keyboard and keeps an 8x5 key matrix in registers. It drives the core's keyboard column inputs (columnas) from the row-select lines (filas, which are the CPU A15..A8). It sits directly upstream of jupiter_ace and stands in for the physical Ace keyboard membrane.

Parameters:
TIMEOUT_CYCLES, 6500, clk cycles with no PS/2 falling edge before a partial frame is abandoned (about 1 ms at 6.5 MHz).

Ports:
clk  input  1  system clock; the same clock domain as clk65 of jupiter_ace
reset  input  1  asynchronous active-low reset
ps2clk  input  1  PS/2 clock from the keyboard, asynchronous
ps2data  input  1  PS/2 data from the keyboard, asynchronous
filas  input  8  row select from the Z80 address bus A15..A8; a row is selected when its bit is 0
columnas  output  5  key columns, active-low; 0 means a pressed key in a selected row
scancode  output  8  last accepted scan byte, for debug
scancode_valid  output  1  one-cycle pulse when scancode updates

Behaviour:
- Reset (reset=0, asynchronous):
  - matrix = all 1 (all keys released); scancode = 8'h00; scancode_valid = 0.
  - Receiver goes to IDLE; the ext and brk flags are cleared.
  - columnas reads 5'b11111.
- Input synchronisation: ps2clk and ps2data pass through 2-FF synchronisers. A falling edge is detected on the synchronised clock (previous=1, current=0). Data is sampled on that edge.
- Receiver FSM:
  - IDLE: on a falling edge with data=0 (start bit), go to RECV with bitcnt=0. A falling edge with data=1 is ignored.
  - RECV: on each falling edge, shift the data bit in LSB first. bitcnt 0..7 are data, bitcnt 8 is parity, bitcnt 9 is stop. After the stop bit, go to CHECK.
  - CHECK (one cycle): accept the byte only if the 8 data bits plus the parity bit have odd parity and stop=1. Then return to IDLE.
  - Timeout: a counter resets on every falling edge. When it reaches TIMEOUT_CYCLES while in RECV, go to IDLE, discard the partial byte and leave the flags unchanged.
  - A rejected frame (parity or stop error) is discarded silently and clears ext and brk.
- Decoder, acting on an accepted byte. scancode and scancode_valid are updated the cycle after CHECK, for every accepted byte, prefixes included.
  - E0: set ext.
  - F0: set brk.
  - Any other code: look up the row/column. If mapped, write matrix[row][col] = brk (1 = released, 0 = pressed). Then clear ext and brk. Unmapped codes (AA, FA, FE, etc.) change only the flags.
  - With ext=1, only 14 is mapped (RCtrl -> SYM SHIFT) and 5A is mapped (keypad Enter -> ENTER). All other E0 codes are ignored.
- Key map (row: col0..col4, hex set-2 codes):
  - r0: SHIFT (12 and 59), SYM (14), Z 1A, X 22, C 21
  - r1: A 1C, S 1B, D 23, F 2B, G 34
  - r2: Q 15, W 1D, E 24, R 2D, T 2C
  - r3: 1 16, 2 1E, 3 26, 4 25, 5 2E
  - r4: 0 45, 9 46, 8 3E, 7 3D, 6 36
  - r5: P 4D, O 44, I 43, U 3C, Y 35
  - r6: ENTER 5A, L 4B, K 42, J 3B, H 33
  - r7: SPACE 29, M 3A, N 31, B 32, V 2A
- Output: columnas[c] = AND over all rows r with filas[r]=0 of matrix[r][c].
  - This path is purely combinational, with zero latency from filas, so the Z80 IN sees it within the same read.
  - filas=8'hFF gives 5'b11111. Several rows selected together AND their columns.
- Simultaneous events: a matrix update and a filas change in the same cycle show the new matrix value on columnas after the clock edge. Reset in the middle of a frame abandons the frame; the first frame after reset decodes normally.

Test Plan:
- Reset asserted with a key held in the matrix -> columnas=5'b11111 for filas=8'hFE, scancode=00, FSM in IDLE.
- Send frame 1C (A) with correct parity, filas=8'hFD -> columnas=5'b11110, scancode_valid pulses once with scancode=1C. Then send F0,1C -> columnas=5'b11111.
- Press 12 (LShift) and 29 (SPACE). filas=8'hFE -> 5'b11110; filas=8'h7F -> 5'b11110; filas=8'h7E -> 5'b11110; filas=8'hFF -> 5'b11111.
- Send E0,14 -> SYM pressed (filas=8'hFE gives 5'b11101). Then send E0,F0,14 -> released. Send E0,75 -> matrix unchanged and flags cleared, so a following 1A presses Z.
- Frame 1C with a flipped parity bit -> no scancode_valid pulse, matrix unchanged. Send 6 bits, then idle TIMEOUT_CYCLES+10 cycles, then a full 1C frame -> only the 1C frame is accepted.
- Assert reset after the 4th bit of a frame, release it, then send 22 -> X pressed (filas=8'hFE gives 5'b10111), with no corruption from the partial frame.
